// File: rtl/step_sequencer_if.sv
// Bundle between the step sequencer, instruction memory and the instruction decoder.
// The sequencer takes the slave side; the decoder/memory/testbench take the master side.
interface step_sequencer_if #(
    parameter int ICNT_W = 16
);
    logic              Start;
    logic              Hold;
    logic [15:0]       MemData;
    logic [1:0]        ALU_Flags;
    logic              Buff_PC;
    logic              Buff_PSW;
    logic              Done;

    logic [2:0]        Cnt;
    logic [15:0]       Ins;
    logic [7:0]        InsM;
    logic [1:0]        InsL;
    logic [1:0]        PSW_NZC;
    logic              Dec_Rst;
    logic              Halted;
    logic              Err;
    logic [ICNT_W-1:0] InsCount;

    modport slave (
        input  Start, Hold, MemData, ALU_Flags, Buff_PC, Buff_PSW, Done,
        output Cnt, Ins, InsM, InsL, PSW_NZC, Dec_Rst, Halted, Err, InsCount
    );

    modport master (
        output Start, Hold, MemData, ALU_Flags, Buff_PC, Buff_PSW, Done,
        input  Cnt, Ins, InsM, InsL, PSW_NZC, Dec_Rst, Halted, Err, InsCount
    );
endinterface

// File: rtl/step_sequencer.sv
// Step counter, instruction register and PSW flags feeding the instruction decoder.
// Ends instructions on decoder strobes, halts on Done, and flags runaway step sequences.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | out of reset, decoder held in reset, waiting for Start
//   S_RUN  | stepping: Cnt==0 fetches, Cnt>0 executes under decoder control
//   S_HALT | halt instruction retired; everything frozen until Start
module step_sequencer #(
    parameter int MAX_STEP = 4,
    parameter int ICNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    step_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [2:0] LP_MAX_STEP = 3'(MAX_STEP);

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic [15:0]         r_ins;
    logic [1:0]          r_psw;
    logic                r_err;
    logic [ICNT_W-1:0]   r_icnt;
    logic                r_dec_rst;
    logic                r_halted;

    state_t              w_state_nxt;
    logic [2:0]          w_cnt_nxt;
    logic [15:0]         w_ins_nxt;
    logic [1:0]          w_psw_nxt;
    logic                w_err_nxt;
    logic [ICNT_W-1:0]   w_icnt_nxt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ins_nxt   = r_ins;
        w_psw_nxt   = r_psw;
        w_err_nxt   = r_err;
        w_icnt_nxt  = r_icnt;

        case (r_state)
            S_IDLE, S_HALT: begin
                if (bus.Start) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 3'd0;
                end
            end

            S_RUN: begin
                if (!bus.Hold) begin
                    if (r_cnt == 3'd0) begin
                        w_ins_nxt = bus.MemData;
                        w_cnt_nxt = 3'd1;
                    end else begin
                        if (bus.Buff_PSW) begin
                            w_psw_nxt = bus.ALU_Flags;
                        end
                        if (bus.Done) begin
                            w_state_nxt = S_HALT;
                            w_cnt_nxt   = 3'd0;
                            w_icnt_nxt  = r_icnt + ICNT_W'(1);
                        end else if (bus.Buff_PC) begin
                            w_cnt_nxt   = 3'd0;
                            w_icnt_nxt  = r_icnt + ICNT_W'(1);
                        end else if (r_cnt >= LP_MAX_STEP) begin
                            // Runaway: drop the instruction uncounted and refetch.
                            w_cnt_nxt   = 3'd0;
                            w_err_nxt   = 1'b1;
                        end else begin
                            w_cnt_nxt   = r_cnt + 3'd1;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Dec_Rst/Halted are registered from the next state so they are glitch-free flops.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt     <= 3'd0;
            r_ins     <= 16'h0000;
            r_psw     <= 2'b00;
            r_err     <= 1'b0;
            r_icnt    <= '0;
            r_dec_rst <= 1'b1;
            r_halted  <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_ins     <= w_ins_nxt;
            r_psw     <= w_psw_nxt;
            r_err     <= w_err_nxt;
            r_icnt    <= w_icnt_nxt;
            r_dec_rst <= (w_state_nxt != S_RUN);
            r_halted  <= (w_state_nxt == S_HALT);
        end
    end

    assign bus.Cnt      = r_cnt;
    assign bus.Ins      = r_ins;
    assign bus.InsM     = r_ins[15:8];
    assign bus.InsL     = r_ins[1:0];
    assign bus.PSW_NZC  = r_psw;
    assign bus.Dec_Rst  = r_dec_rst;
    assign bus.Halted   = r_halted;
    assign bus.Err      = r_err;
    assign bus.InsCount = r_icnt;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: stimulus pushes hand-computed expectations,
// independent monitors pop them after each clock edge and on asynchronous reset.
module tb_step_sequencer;

    logic Clk;
    logic Rst_n;

    step_sequencer_if #(.ICNT_W(16)) bus ();

    step_sequencer #(.MAX_STEP(4), .ICNT_W(16)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  cnt;
        logic [15:0] ins;
        logic [1:0]  psw;
        logic        dr;
        logic        h;
        logic        err;
        logic [15:0] ic;
    } exp_t;

    exp_t exp_q[$];
    exp_t rst_q[$];

    int checks = 0;
    int errors = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        logic [15:0] ins_e;
        ins_e = e.ins;
        chk({tag, ".Cnt"},      32'(bus.Cnt),      32'(e.cnt));
        chk({tag, ".Ins"},      32'(bus.Ins),      32'(ins_e));
        chk({tag, ".InsM"},     32'(bus.InsM),     32'(ins_e[15:8]));
        chk({tag, ".InsL"},     32'(bus.InsL),     32'(ins_e[1:0]));
        chk({tag, ".PSW_NZC"},  32'(bus.PSW_NZC),  32'(e.psw));
        chk({tag, ".Dec_Rst"},  32'(bus.Dec_Rst),  32'(e.dr));
        chk({tag, ".Halted"},   32'(bus.Halted),   32'(e.h));
        chk({tag, ".Err"},      32'(bus.Err),      32'(e.err));
        chk({tag, ".InsCount"}, 32'(bus.InsCount), 32'(e.ic));
    endtask

    always begin
        @(posedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            compare("step", e);
        end
    end

    always begin
        @(negedge Rst_n);
        #1;
        if (rst_q.size() > 0) begin
            exp_t e;
            e = rst_q.pop_front();
            compare("async_rst", e);
        end
    end

    // One clock: drive inputs mid-cycle, expect the listed outputs after the next edge.
    task automatic cyc(input logic st, input logic hd, input logic [15:0] md,
                       input logic [1:0] fl, input logic bpc, input logic bpsw, input logic dn,
                       input logic [2:0] c, input logic [15:0] ins, input logic [1:0] psw,
                       input logic dr, input logic h, input logic er, input logic [15:0] ic);
        exp_t e;
        @(negedge Clk);
        bus.Start     = st;
        bus.Hold      = hd;
        bus.MemData   = md;
        bus.ALU_Flags = fl;
        bus.Buff_PC   = bpc;
        bus.Buff_PSW  = bpsw;
        bus.Done      = dn;
        e.cnt = c; e.ins = ins; e.psw = psw; e.dr = dr; e.h = h; e.err = er; e.ic = ic;
        exp_q.push_back(e);
    endtask

    task automatic async_reset();
        exp_t e;
        e.cnt = 3'd0; e.ins = 16'h0000; e.psw = 2'b00; e.dr = 1'b1;
        e.h = 1'b0; e.err = 1'b0; e.ic = 16'h0000;
        @(negedge Clk);
        bus.Start = 1'b0; bus.Hold = 1'b0; bus.Buff_PC = 1'b0;
        bus.Buff_PSW = 1'b0; bus.Done = 1'b0;
        rst_q.push_back(e);
        #2 Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst_n = 1'b1;
        bus.Start = 1'b0; bus.Hold = 1'b0; bus.MemData = 16'h0000; bus.ALU_Flags = 2'b00;
        bus.Buff_PC = 1'b0; bus.Buff_PSW = 1'b0; bus.Done = 1'b0;

        async_reset();

        //  st hd mem       fl    bpc psw dn | cnt ins       psw   dr h  er ic
        cyc(0, 0, 16'h0800, 2'b00, 0, 0, 0,   0, 16'h0000, 2'b00, 1, 0, 0, 16'd0);
        cyc(1, 0, 16'h0800, 2'b00, 0, 0, 0,   0, 16'h0000, 2'b00, 0, 0, 0, 16'd0);
        cyc(0, 0, 16'h0800, 2'b00, 0, 0, 0,   1, 16'h0800, 2'b00, 0, 0, 0, 16'd0);
        cyc(0, 0, 16'h1234, 2'b00, 0, 0, 0,   2, 16'h0800, 2'b00, 0, 0, 0, 16'd0);
        cyc(0, 0, 16'h1234, 2'b00, 1, 0, 0,   0, 16'h0800, 2'b00, 0, 0, 0, 16'd1);
        // PSW strobe at fetch is ignored; commit coincides with Buff_PC
        cyc(0, 0, 16'h4A03, 2'b11, 0, 1, 0,   1, 16'h4A03, 2'b00, 0, 0, 0, 16'd1);
        cyc(0, 0, 16'h4A03, 2'b00, 0, 0, 0,   2, 16'h4A03, 2'b00, 0, 0, 0, 16'd1);
        cyc(0, 0, 16'h4A03, 2'b10, 1, 1, 0,   0, 16'h4A03, 2'b10, 0, 0, 0, 16'd2);
        cyc(0, 0, 16'h0001, 2'b01, 0, 0, 0,   1, 16'h0001, 2'b10, 0, 0, 0, 16'd2);
        cyc(0, 0, 16'h0001, 2'b01, 1, 0, 0,   0, 16'h0001, 2'b10, 0, 0, 0, 16'd3);
        // runaway instruction: 0..4 then back to 0 with Err, not counted
        cyc(0, 0, 16'h00FF, 2'b00, 0, 0, 0,   1, 16'h00FF, 2'b10, 0, 0, 0, 16'd3);
        cyc(0, 0, 16'h00FF, 2'b00, 0, 0, 0,   2, 16'h00FF, 2'b10, 0, 0, 0, 16'd3);
        cyc(0, 0, 16'h00FF, 2'b00, 0, 0, 0,   3, 16'h00FF, 2'b10, 0, 0, 0, 16'd3);
        cyc(0, 0, 16'h00FF, 2'b00, 0, 0, 0,   4, 16'h00FF, 2'b10, 0, 0, 0, 16'd3);
        cyc(0, 0, 16'h00FF, 2'b00, 0, 0, 0,   0, 16'h00FF, 2'b10, 0, 0, 1, 16'd3);
        cyc(0, 0, 16'h0802, 2'b00, 0, 0, 0,   1, 16'h0802, 2'b10, 0, 0, 1, 16'd3);
        cyc(0, 0, 16'h0802, 2'b00, 1, 0, 0,   0, 16'h0802, 2'b10, 0, 0, 1, 16'd4);
        // Hold for 3 cycles at Cnt=2 with strobes active
        cyc(0, 0, 16'h1100, 2'b00, 0, 0, 0,   1, 16'h1100, 2'b10, 0, 0, 1, 16'd4);
        cyc(0, 0, 16'h1100, 2'b00, 0, 0, 0,   2, 16'h1100, 2'b10, 0, 0, 1, 16'd4);
        cyc(0, 1, 16'h5555, 2'b01, 1, 1, 0,   2, 16'h1100, 2'b10, 0, 0, 1, 16'd4);
        cyc(0, 1, 16'h5555, 2'b01, 1, 1, 0,   2, 16'h1100, 2'b10, 0, 0, 1, 16'd4);
        cyc(0, 1, 16'h5555, 2'b01, 1, 1, 1,   2, 16'h1100, 2'b10, 0, 0, 1, 16'd4);
        cyc(0, 0, 16'h5555, 2'b01, 1, 0, 0,   0, 16'h1100, 2'b10, 0, 0, 1, 16'd5);
        // Done at Cnt=3 wins over Buff_PC, then HALT is frozen
        cyc(0, 0, 16'h2200, 2'b00, 0, 0, 0,   1, 16'h2200, 2'b10, 0, 0, 1, 16'd5);
        cyc(0, 0, 16'h2200, 2'b00, 0, 0, 0,   2, 16'h2200, 2'b10, 0, 0, 1, 16'd5);
        cyc(0, 0, 16'h2200, 2'b00, 0, 0, 0,   3, 16'h2200, 2'b10, 0, 0, 1, 16'd5);
        cyc(0, 0, 16'h2200, 2'b00, 1, 0, 1,   0, 16'h2200, 2'b10, 1, 1, 1, 16'd6);
        cyc(0, 0, 16'h3300, 2'b11, 1, 1, 1,   0, 16'h2200, 2'b10, 1, 1, 1, 16'd6);
        cyc(0, 0, 16'h3300, 2'b11, 0, 1, 0,   0, 16'h2200, 2'b10, 1, 1, 1, 16'd6);
        // Start with Hold: enter RUN, then Hold is honoured before the fetch
        cyc(1, 1, 16'h3300, 2'b00, 0, 0, 0,   0, 16'h2200, 2'b10, 0, 0, 1, 16'd6);
        cyc(0, 1, 16'h3300, 2'b00, 0, 0, 0,   0, 16'h2200, 2'b10, 0, 0, 1, 16'd6);
        cyc(0, 0, 16'h3300, 2'b00, 0, 0, 0,   1, 16'h3300, 2'b10, 0, 0, 1, 16'd6);
        cyc(0, 0, 16'h3300, 2'b00, 0, 0, 0,   2, 16'h3300, 2'b10, 0, 0, 1, 16'd6);
        cyc(0, 0, 16'h3300, 2'b11, 0, 1, 0,   3, 16'h3300, 2'b11, 0, 0, 1, 16'd6);

        // Cnt=3, PSW=11: asynchronous reset mid-cycle
        async_reset();

        cyc(0, 0, 16'hABCD, 2'b00, 0, 0, 0,   0, 16'h0000, 2'b00, 1, 0, 0, 16'd0);
        cyc(1, 0, 16'hABCD, 2'b00, 0, 0, 0,   0, 16'h0000, 2'b00, 0, 0, 0, 16'd0);
        cyc(0, 0, 16'hABCD, 2'b00, 0, 0, 0,   1, 16'hABCD, 2'b00, 0, 0, 0, 16'd0);

        repeat (3) @(negedge Clk);
        chk("queue_drained", 32'(exp_q.size() + rst_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
